// File: rtl/maxnet_model.sv
// Four-neuron MAXNET winner-take-all engine over fp32 values.
// One shared fp adder and multiplier are stepped four ops per neuron, 16 cycles per update.
module maxnet_model #(
    parameter int unsigned MAX_ITER = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] eps,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] a3,
    input  logic [31:0] a4,
    output logic        finish,
    output logic [31:0] out
);

    localparam int unsigned CntW = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    // Round-to-nearest-even on a 24-bit mantissa plus guard/round/sticky, then pack.
    // Underflow flushes to +0 and overflow saturates to the signed max finite value.
    function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e_in,
                                               input logic [26:0] m);
        logic              up;
        logic [24:0]       rnd;
        logic [22:0]       frac;
        logic signed [9:0] e;
        logic [31:0]       res;
        up  = m[2] & (m[1] | m[0] | m[3]);
        rnd = {1'b0, m[26:3]} + {24'd0, up};
        e   = e_in;
        if (rnd[24]) begin
            frac = rnd[23:1];
            e    = e + 10'sd1;
        end else begin
            frac = rnd[22:0];
        end
        if (e <= 10'sd0) begin
            res = 32'h0000_0000;
        end else if (e >= 10'sd255) begin
            res = {s, 8'hFE, 23'h7F_FFFF};
        end else begin
            res = {s, e[7:0], frac};
        end
        return res;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big;
        logic [31:0]       sml;
        logic [7:0]        ed;
        logic [26:0]       mb;
        logic [26:0]       mb_sh;
        logic [26:0]       mask;
        logic [26:0]       diff;
        logic [26:0]       m;
        logic [27:0]       sum;
        logic [4:0]        lz;
        logic signed [9:0] e;
        logic [31:0]       res;
        big   = a;
        sml   = b;
        ed    = '0;
        mb    = '0;
        mb_sh = '0;
        mask  = '0;
        diff  = '0;
        m     = '0;
        sum   = '0;
        lz    = '0;
        e     = '0;
        res   = '0;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
            res = {a[31] & b[31], 31'd0};
        end else if (a[30:23] == 8'd0) begin
            res = b;
        end else if (b[30:23] == 8'd0) begin
            res = a;
        end else begin
            if (a[30:0] < b[30:0]) begin
                big = b;
                sml = a;
            end
            ed = big[30:23] - sml[30:23];
            mb = {1'b1, sml[22:0], 3'b000};
            if (ed >= 8'd27) begin
                mb_sh = 27'd1;
            end else begin
                mask  = (27'd1 << ed) - 27'd1;
                mb_sh = (mb >> ed) | {26'd0, |(mb & mask)};
            end
            e = $signed({2'b00, big[30:23]});
            if (big[31] == sml[31]) begin
                sum = {1'b0, 1'b1, big[22:0], 3'b000} + {1'b0, mb_sh};
                if (sum[27]) begin
                    m = {sum[27:2], sum[1] | sum[0]};
                    e = e + 10'sd1;
                end else begin
                    m = sum[26:0];
                end
                res = round_pack(big[31], e, m);
            end else begin
                diff = {1'b1, big[22:0], 3'b000} - mb_sh;
                for (int k = 0; k < 27; k++) begin
                    if (diff[k]) lz = 5'(26 - k);
                end
                m   = diff << lz;
                e   = e - $signed({5'd0, lz});
                res = (diff == 27'd0) ? 32'h0000_0000 : round_pack(big[31], e, m);
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       p;
        logic [26:0]       m;
        logic signed [9:0] e;
        logic [31:0]       res;
        p   = '0;
        m   = '0;
        e   = '0;
        res = '0;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            res = {a[31] ^ b[31], 31'd0};
        end else begin
            p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
            e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            if (p[47]) begin
                m = {p[47:22], |p[21:0]};
                e = e + 10'sd1;
            end else begin
                m = {p[46:21], |p[20:0]};
            end
            res = round_pack(a[31] ^ b[31], e, m);
        end
        return res;
    endfunction

    // k-th neuron (ascending) among the three that are not self.
    function automatic logic [1:0] other_idx(input logic [1:0] self, input logic [1:0] k);
        return (k >= self) ? k + 2'd1 : k;
    endfunction

    state_e               state_q, state_d;
    logic [3:0][31:0]     x_q, x_d;
    logic [3:0][31:0]     xn_q, xn_d;
    logic [3:0][31:0]     orig_q, orig_d;
    logic [31:0]          eps_q, eps_d;
    logic [31:0]          acc_q, acc_d;
    logic [1:0]           nidx_q, nidx_d;
    logic [1:0]           step_q, step_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [CntW-1:0]      cnt_inc;
    logic [31:0]          out_q, out_d;
    logic                 finish_q, finish_d;

    logic [31:0]          add_a, add_b, add_y, mul_y, relu_y;
    logic [3:0][31:0]     x_upd;
    logic [2:0]           n_pos;
    logic [1:0]           first_pos;

    // Per neuron: step 0/1 accumulate the other three, step 2 scales by eps, step 3 adds self.
    always_comb begin
        add_a = acc_q;
        add_b = x_q[other_idx(nidx_q, 2'd2)];
        unique case (step_q)
            2'd0: begin
                add_a = x_q[other_idx(nidx_q, 2'd0)];
                add_b = x_q[other_idx(nidx_q, 2'd1)];
            end
            2'd3: begin
                add_a = x_q[nidx_q];
                add_b = acc_q;
            end
            default: ;
        endcase
    end

    assign add_y   = fp_add(add_a, add_b);
    assign mul_y   = fp_mul(eps_q, acc_q);
    assign relu_y  = add_y[31] ? 32'h0000_0000 : add_y;
    assign cnt_inc = cnt_q + CntW'(1);

    // Vector as it stands once the last neuron of this update is written.
    always_comb begin
        x_upd     = xn_q;
        x_upd[3]  = relu_y;
        n_pos     = '0;
        first_pos = '0;
        for (int k = 3; k >= 0; k--) begin
            if (x_upd[k][30:0] != 31'd0 && !x_upd[k][31]) begin
                n_pos     = n_pos + 3'd1;
                first_pos = 2'(k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        xn_d     = xn_q;
        orig_d   = orig_q;
        eps_d    = eps_q;
        acc_d    = acc_q;
        nidx_d   = nidx_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        finish_d = finish_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    x_d      = {a4, a3, a2, a1};
                    orig_d   = {a4, a3, a2, a1};
                    eps_d    = eps;
                    nidx_d   = '0;
                    step_d   = '0;
                    cnt_d    = '0;
                    finish_d = 1'b0;
                    state_d  = StIter;
                end
            end
            StIter: begin
                unique case (step_q)
                    2'd0, 2'd1: acc_d = add_y;
                    2'd2:       acc_d = mul_y;
                    default: begin
                        xn_d[nidx_q] = relu_y;
                        if (nidx_q == 2'd3) begin
                            x_d   = x_upd;
                            cnt_d = cnt_inc;
                            if (n_pos == 3'd0) begin
                                out_d    = 32'h0000_0000;
                                finish_d = 1'b1;
                                state_d  = StDone;
                            end else if (n_pos == 3'd1 || cnt_inc == CntW'(MAX_ITER)) begin
                                out_d    = orig_q[first_pos];
                                finish_d = 1'b1;
                                state_d  = StDone;
                            end
                        end
                        nidx_d = nidx_q + 2'd1;
                    end
                endcase
                step_d = step_q + 2'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            xn_q     <= '0;
            orig_q   <= '0;
            eps_q    <= '0;
            acc_q    <= '0;
            nidx_q   <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            xn_q     <= xn_d;
            orig_q   <= orig_d;
            eps_q    <= eps_d;
            acc_q    <= acc_d;
            nidx_q   <= nidx_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            finish_q <= finish_d;
        end
    end

    assign finish = finish_q;
    assign out    = out_q;

endmodule

// File: tb/tb_maxnet_model.sv
// Directed-vector bench for maxnet_model with hand-computed winners.
module tb_maxnet_model;

    localparam logic [31:0] EpsM02 = 32'hBE4C_CCCD;
    localparam logic [31:0] NegOne = 32'hBF80_0000;
    localparam int          Budget = 100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] eps;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] a3;
    logic [31:0] a4;
    logic        finish;
    logic [31:0] dut_out;

    int n_vec = 0;
    int n_err = 0;
    int cycles;

    maxnet_model #(
        .MAX_ITER(255)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .eps   (eps),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .a4    (a4),
        .finish(finish),
        .out   (dut_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
        end
    endtask

    // Start pulse, then scramble the inputs to show they are no longer looked at.
    task automatic launch(input string tag, input logic [31:0] e, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3, input logic [31:0] v4);
        @(negedge clk);
        eps   = e;
        a1    = v1;
        a2    = v2;
        a3    = v3;
        a4    = v4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        eps   = 32'h0000_0000;
        a1    = 32'h42C8_0000;
        a2    = 32'h42C8_0000;
        a3    = 32'h42C8_0000;
        a4    = 32'h42C8_0000;
        check_eq({tag, "_fin_clr"}, {31'd0, finish}, 32'd0);
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!finish && n < Budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, {31'd0, finish}, 32'd1);
    endtask

    task automatic expect_result(input string tag, input logic [31:0] exp);
        check_eq({tag, "_out"}, dut_out, exp);
        repeat (4) @(negedge clk);
        check_eq({tag, "_fin_hold"}, {31'd0, finish}, 32'd1);
        check_eq({tag, "_out_hold"}, dut_out, exp);
    endtask

    task automatic run_case(input string tag, input logic [31:0] e, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] v3, input logic [31:0] v4,
                            input logic [31:0] exp, output int n);
        launch(tag, e, v1, v2, v3, v4);
        wait_done(tag, n);
        expect_result(tag, exp);
    endtask

    initial begin
        // Reset held together with a start request: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        eps   = EpsM02;
        a1    = NegOne;
        a2    = NegOne;
        a3    = NegOne;
        a4    = NegOne;
        repeat (3) @(negedge clk);
        check_eq("rst_fin", {31'd0, finish}, 32'd0);
        check_eq("rst_out", dut_out, 32'h0000_0000);
        rst   = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("idle_fin", {31'd0, finish}, 32'd0);
        check_eq("idle_out", dut_out, 32'h0000_0000);

        run_case("t1_big", EpsM02, 32'h461C_3FA7, 32'hC61C_3FA7, 32'h3FA6_6666, 32'hC61C_3FA7,
                 32'h461C_3FA7, cycles);
        run_case("t2_ramp", EpsM02, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                 32'h4080_0000, cycles);
        run_case("t3_neg", EpsM02, NegOne, NegOne, NegOne, NegOne, 32'h0000_0000, cycles);
        run_case("t4_tie", EpsM02, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000,
                 32'h4000_0000, cycles);
        check_eq("t4_tie_len", (cycles >= 255) ? 32'd1 : 32'd0, 32'd1);
        run_case("t7_close", EpsM02, 32'h4040_0000, 32'h4046_6666, 32'h0000_0000, 32'h0000_0000,
                 32'h4046_6666, cycles);
        run_case("t8_mid", EpsM02, 32'h3F00_0000, NegOne, 32'h4120_0000, 32'h40A0_0000,
                 32'h4120_0000, cycles);

        // Start during a run is ignored.
        launch("t5_ign", EpsM02, 32'h461C_3FA7, 32'hC61C_3FA7, 32'h3FA6_6666, 32'hC61C_3FA7);
        repeat (10) @(negedge clk);
        eps   = EpsM02;
        a1    = 32'h3F80_0000;
        a2    = 32'h4000_0000;
        a3    = 32'h4040_0000;
        a4    = 32'h4080_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_ign", cycles);
        expect_result("t5_ign", 32'h461C_3FA7);

        // Reset mid-run aborts and clears the result.
        launch("t5_rst", EpsM02, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t5_rst_fin", {31'd0, finish}, 32'd0);
        check_eq("t5_rst_out", dut_out, 32'h0000_0000);
        repeat (200) @(negedge clk);
        check_eq("t5_rst_abort", {31'd0, finish}, 32'd0);
        run_case("t5_fresh", EpsM02, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                 32'h4080_0000, cycles);

        // Back-to-back from DONE: result moves from 0 to the new winner.
        run_case("t6_zero", EpsM02, NegOne, NegOne, NegOne, NegOne, 32'h0000_0000, cycles);
        run_case("t6_b2b", EpsM02, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                 32'h4080_0000, cycles);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
